// File: rtl/mult_stage_pipe_pkg.sv
// PE datapath configuration and multiply-stage control types.
// MSbeat is the stage-register layout at the default PE geometry.
package PECfg;
  localparam int PE_DWD     = 8;
  localparam int PE_PSUMDWD = 16;
  localparam int PE_PEROW   = 4;
endpackage

package PECtlCfg;
  import PECfg::*;

  localparam int PE_SIDEW = 8;

  typedef enum logic [1:0] {
    MS_FULL = 2'd0,
    MS_DUAL = 2'd1,
    MS_BYP  = 2'd2,
    MS_RSV  = 2'd3
  } MSmode;

  typedef struct packed {
    logic [PE_PEROW*2*PE_DWD-1:0]  sum;
    logic [PE_PEROW*PE_PSUMDWD-1:0] psum;
    logic [PE_SIDEW-1:0]            side;
  } MSbeat;
endpackage

// File: rtl/mult_stage_pipe_lane.sv
// One row of the multiply stage: combinational, zero latency, no flow control.
// Full signed multiply, packed dual half-width MAC, bypass, or zero.
module mult_lane
  import PECtlCfg::*;
#(
  parameter int DWD = 8
) (
  input  logic [DWD-1:0]   ipix_i,
  input  logic [DWD-1:0]   wpix_i,
  input  MSmode            mode_i,
  output logic [2*DWD-1:0] sum_o
);

  localparam int HW = DWD / 2;

  logic signed [2*DWD-1:0] ip_x, wp_x, ihi_x, ilo_x, whi_x, wlo_x;

  always_comb begin
    ip_x  = {{DWD{ipix_i[DWD-1]}}, ipix_i};
    wp_x  = {{DWD{wpix_i[DWD-1]}}, wpix_i};
    ihi_x = {{(2*DWD-HW){ipix_i[DWD-1]}}, ipix_i[DWD-1:HW]};
    ilo_x = {{(2*DWD-HW){ipix_i[HW-1]}},  ipix_i[HW-1:0]};
    whi_x = {{(2*DWD-HW){wpix_i[DWD-1]}}, wpix_i[DWD-1:HW]};
    wlo_x = {{(2*DWD-HW){wpix_i[HW-1]}},  wpix_i[HW-1:0]};
    sum_o = '0;
    case (mode_i)
      MS_FULL: sum_o = ip_x * wp_x;
      MS_DUAL: sum_o = ihi_x * whi_x + ilo_x * wlo_x;
      MS_BYP:  sum_o = ip_x;
      default: sum_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_stage_pipe.sv
// PE multiply stage: PEROW lanes into an NSTAGE valid pipeline, latency NSTAGE, 1 beat/cycle.
// Bubbles collapse; o_FS_ack falls only when the last stage is stalled by i_MS_ack or on flush.
module mult_stage_pipe
  import PECfg::*;
  import PECtlCfg::*;
#(
  parameter int DWD     = PE_DWD,
  parameter int PSUMDWD = PE_PSUMDWD,
  parameter int PEROW   = PE_PEROW,
  parameter int NSTAGE  = 2,
  parameter int SIDEW   = PE_SIDEW,
  parameter int CNTW    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_FS_rdy,
  output logic                       o_FS_ack,
  input  logic [PEROW*DWD-1:0]       i_ipix,
  input  logic [PEROW*DWD-1:0]       i_wpix,
  input  logic [PEROW*PSUMDWD-1:0]   i_psum,
  input  logic [1:0]                 i_mode,
  input  logic [SIDEW-1:0]           i_side,
  output logic                       o_MS_rdy,
  input  logic                       i_MS_ack,
  output logic [PEROW*2*DWD-1:0]     o_sum,
  output logic [PEROW*PSUMDWD-1:0]   o_psum,
  output logic [SIDEW-1:0]           o_side,
  input  logic                       i_flush,
  input  logic                       i_clr,
  output logic [CNTW-1:0]            o_beat_cnt
);

  // MSbeat layout, sized by this instance's parameters
  typedef struct packed {
    logic [PEROW*2*DWD-1:0]   sum;
    logic [PEROW*PSUMDWD-1:0] psum;
    logic [SIDEW-1:0]         side;
  } beat_t;

  beat_t                  cap_beat;
  beat_t                  stg_q [NSTAGE];
  beat_t                  stg_d [NSTAGE];
  logic [NSTAGE-1:0]      v_q, v_d, adv;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [PEROW*2*DWD-1:0] lane_sum;
  logic                   in_xfer, out_xfer;

  for (genvar r = 0; r < PEROW; r++) begin : g_lane
    mult_lane #(.DWD(DWD)) u_lane (
      .ipix_i (i_ipix[r*DWD +: DWD]),
      .wpix_i (i_wpix[r*DWD +: DWD]),
      .mode_i (MSmode'(i_mode)),
      .sum_o  (lane_sum[r*2*DWD +: 2*DWD])
    );
  end

  always_comb begin
    cap_beat      = '0;
    cap_beat.sum  = lane_sum;
    cap_beat.psum = i_psum;
    cap_beat.side = i_side;
  end

  // A stage moves when its successor is empty or moving in the same cycle
  always_comb begin
    adv = '0;
    adv[NSTAGE-1] = v_q[NSTAGE-1] & i_MS_ack;
    for (int k = NSTAGE - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign out_xfer = adv[NSTAGE-1];
  assign o_FS_ack = i_rst | (~i_flush & (~v_q[0] | adv[0]));
  assign in_xfer  = i_FS_rdy & o_FS_ack;

  always_comb begin
    v_d   = v_q;
    stg_d = stg_q;
    if (in_xfer) begin
      v_d[0]   = 1'b1;
      stg_d[0] = cap_beat;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int k = 1; k < NSTAGE; k++) begin
      if (adv[k-1]) begin
        v_d[k]   = 1'b1;
        stg_d[k] = stg_q[k-1];
      end else if (adv[k]) begin
        v_d[k] = 1'b0;
      end
    end
    if (i_flush) v_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)         cnt_d = '0;
    else if (out_xfer) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < NSTAGE; k++) stg_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      stg_q <= stg_d;
    end
  end

  assign o_MS_rdy   = v_q[NSTAGE-1];
  assign o_sum      = stg_q[NSTAGE-1].sum;
  assign o_psum     = stg_q[NSTAGE-1].psum;
  assign o_side     = stg_q[NSTAGE-1].side;
  assign o_beat_cnt = cnt_q;

endmodule

// File: tb/tb_mult_stage_pipe.sv
// Directed-vector and scoreboard bench for mult_stage_pipe (default geometry, NSTAGE=2),
// with a CNTW=4 twin on the same stimulus to exercise counter wrap.
module tb_mult_stage_pipe;
  localparam int DWD = 8, PSUMDWD = 16, PEROW = 4, SIDEW = 8, CNTW = 16;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                     i_rst, i_FS_rdy, i_MS_ack, i_flush, i_clr;
  logic [PEROW*DWD-1:0]     i_ipix, i_wpix;
  logic [PEROW*PSUMDWD-1:0] i_psum;
  logic [1:0]               i_mode;
  logic [SIDEW-1:0]         i_side;
  logic                     o_FS_ack, o_MS_rdy, u4_fs_ack, u4_ms_rdy;
  logic [PEROW*2*DWD-1:0]   o_sum, u4_sum;
  logic [PEROW*PSUMDWD-1:0] o_psum, u4_psum;
  logic [SIDEW-1:0]         o_side, u4_side;
  logic [CNTW-1:0]          o_beat_cnt;
  logic [3:0]               u4_cnt;

  mult_stage_pipe u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_FS_rdy(i_FS_rdy), .o_FS_ack(o_FS_ack),
    .i_ipix(i_ipix), .i_wpix(i_wpix), .i_psum(i_psum), .i_mode(i_mode), .i_side(i_side),
    .o_MS_rdy(o_MS_rdy), .i_MS_ack(i_MS_ack), .o_sum(o_sum), .o_psum(o_psum), .o_side(o_side),
    .i_flush(i_flush), .i_clr(i_clr), .o_beat_cnt(o_beat_cnt)
  );

  mult_stage_pipe #(.CNTW(4)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_FS_rdy(i_FS_rdy), .o_FS_ack(u4_fs_ack),
    .i_ipix(i_ipix), .i_wpix(i_wpix), .i_psum(i_psum), .i_mode(i_mode), .i_side(i_side),
    .o_MS_rdy(u4_ms_rdy), .i_MS_ack(i_MS_ack), .o_sum(u4_sum), .o_psum(u4_psum), .o_side(u4_side),
    .i_flush(i_flush), .i_clr(i_clr), .o_beat_cnt(u4_cnt)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] ip;
    logic [31:0] wp;
    logic [63:0] ps;
    logic [7:0]  sd;
    logic [63:0] esum;
  } vec_t;

  vec_t        tv [6];
  vec_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_in  = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ref_sum(input logic [1:0] m, input logic [31:0] ip,
                                          input logic [31:0] wp);
    logic [63:0] r;
    logic [7:0]  x, y;
    logic [3:0]  xh, xl, yh, yl;
    int          a, b, ah, al, bh, bl, p;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      x = ip[l*8 +: 8];  y = wp[l*8 +: 8];
      xh = x[7:4]; xl = x[3:0]; yh = y[7:4]; yl = y[3:0];
      a  = $signed(x);  b  = $signed(y);
      ah = $signed(xh); al = $signed(xl); bh = $signed(yh); bl = $signed(yl);
      case (m)
        2'd0:    p = a * b;
        2'd1:    p = ah * bh + al * bl;
        2'd2:    p = a;
        default: p = 0;
      endcase
      r[l*16 +: 16] = p[15:0];
    end
    return r;
  endfunction

  // One clock: drive after the edge, then at the falling edge check counters and scoreboard
  task automatic cyc(input logic rdy, input logic ack, input logic fl, input logic cl,
                     input vec_t v);
    vec_t e;
    @(posedge i_clk); #1;
    i_FS_rdy = rdy; i_MS_ack = ack; i_flush = fl; i_clr = cl;
    i_mode = v.mode; i_ipix = v.ip; i_wpix = v.wp; i_psum = v.ps; i_side = v.sd;
    @(negedge i_clk);
    chk("beat_cnt",  64'(o_beat_cnt), 64'(exp_cnt));
    chk("beat_cnt4", 64'(u4_cnt),     64'(exp_cnt[3:0]));
    if (i_MS_ack && (o_MS_rdy || u4_ms_rdy)) begin
      chk("out_rdy_both", 64'({o_MS_rdy, u4_ms_rdy}), 64'd3);
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_beat: got sum %0h, want no beat", o_sum);
      end else begin
        e = sb.pop_front();
        chk("out_sum",   o_sum,          e.esum);
        chk("out_psum",  o_psum,         e.ps);
        chk("out_side",  64'(o_side),    64'(e.sd));
        chk("out_sum4",  u4_sum,         e.esum);
        chk("out_psum4", u4_psum,        e.ps);
        chk("out_side4", 64'(u4_side),   64'(e.sd));
      end
    end
    if (i_FS_rdy && (o_FS_ack || u4_fs_ack)) begin
      chk("in_ack_both", 64'({o_FS_ack, u4_fs_ack}), 64'd3);
      sb.push_back(v);
      n_in++;
    end
    if (fl) sb.delete();
    if (cl) exp_cnt = '0;
    else if (i_MS_ack && o_MS_rdy) exp_cnt++;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_FS_rdy = 1'b1; i_MS_ack = 1'b0; i_flush = 1'b0; i_clr = 1'b0;
    i_mode = 2'd0; i_ipix = 32'h1234_5678; i_wpix = 32'h0101_0101;
    i_psum = 64'hAAAA_BBBB_CCCC_DDDD; i_side = 8'h77;
    @(negedge i_clk);
    chk("ack_in_rst",  64'(o_FS_ack),  64'd1);
    chk("ack_in_rst4", 64'(u4_fs_ack), 64'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_FS_rdy = 1'b0;
    @(negedge i_clk);
    chk("rst_rdy",  64'(o_MS_rdy),   64'd0);
    chk("rst_sum",  o_sum,           64'd0);
    chk("rst_psum", o_psum,          64'd0);
    chk("rst_side", 64'(o_side),     64'd0);
    chk("rst_cnt",  64'(o_beat_cnt), 64'd0);
    chk("rst_cnt4", 64'(u4_cnt),     64'd0);
    sb.delete();
    exp_cnt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, rv;
    int   cycles;
    i_rst = 1'b1; i_FS_rdy = 1'b0; i_MS_ack = 1'b0; i_flush = 1'b0; i_clr = 1'b0;
    i_ipix = '0; i_wpix = '0; i_psum = '0; i_mode = '0; i_side = '0;

    // Lane order is {lane3, lane2, lane1, lane0}
    tv[0] = '{mode: 2'd0, ip: 32'h7F80_05FD, wp: 32'h8180_0407,
              ps: 64'h1111_2222_3333_4444, sd: 8'hA5, esum: 64'hC0FF_4000_0014_FFEB};
    tv[1] = '{mode: 2'd1, ip: 32'h007F_883F, wp: 32'hFF81_882E,
              ps: 64'hDEAD_BEEF_0123_4567, sd: 8'h3C, esum: 64'h0000_FFC7_0080_0008};
    tv[2] = '{mode: 2'd2, ip: 32'hFF01_7F80, wp: 32'h1234_5678,
              ps: 64'h0000_0000_0000_0000, sd: 8'hFF, esum: 64'hFFFF_0001_007F_FF80};
    tv[3] = '{mode: 2'd3, ip: 32'h7F7F_7F7F, wp: 32'h7F7F_7F7F,
              ps: 64'hFFFF_0000_FFFF_0000, sd: 8'h5A, esum: 64'h0000_0000_0000_0000};
    tv[4] = '{mode: 2'd0, ip: 32'h00FF_0102, wp: 32'h55FF_FF03,
              ps: 64'h0123_4567_89AB_CDEF, sd: 8'h01, esum: 64'h0000_0001_FFFF_0006};
    tv[5] = '{mode: 2'd1, ip: 32'h108F_8077, wp: 32'h0171_8077,
              ps: 64'h8000_7FFF_0001_FFFE, sd: 8'h80, esum: 64'h0000_FFC7_0040_0062};

    do_reset();

    // Back-to-back stream: first output two cycles after first accept, then one per cycle
    for (int i = 0; i < 8; i++) begin
      v = '0;
      if (i < 6) v = tv[i];
      cyc(i < 6, 1'b1, 1'b0, 1'b0, v);
      chk("lat_rdy",  64'(o_MS_rdy), 64'(i >= 2));
      chk("tput_ack", 64'(o_FS_ack), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("empty_rdy", 64'(o_MS_rdy), 64'd0);
    end
    chk("cnt_after_table", 64'(o_beat_cnt), 64'd6);

    // Fill under backpressure, hold, then release
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[0]);
    chk("bp_ack0", 64'(o_FS_ack), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[1]);
    chk("bp_ack1", 64'(o_FS_ack), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[2]);
    chk("bp_full_ack", 64'(o_FS_ack), 64'd0);
    chk("bp_full_rdy", 64'(o_MS_rdy), 64'd1);
    chk("bp_sum",      o_sum, 64'hC0FF_4000_0014_FFEB);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[2]);
    chk("bp_hold_sum", o_sum, 64'hC0FF_4000_0014_FFEB);
    chk("bp_hold_ack", 64'(o_FS_ack), 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, tv[2]);
    chk("bp_release_ack", 64'(o_FS_ack), 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_cnt",     64'(o_beat_cnt), 64'd9);

    // Flush while the last stage transfers: that beat counts, the other is dropped
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[3]);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[4]);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, tv[5]);
    chk("flush_ack", 64'(o_FS_ack), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("flush_rdy", 64'(o_MS_rdy), 64'd0);
    chk("flush_cnt", 64'(o_beat_cnt), 64'd10);
    // Flush with no downstream ack: counter unchanged
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[0]);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tv[1]);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("flush2_rdy", 64'(o_MS_rdy), 64'd0);
    chk("flush2_cnt", 64'(o_beat_cnt), 64'd10);

    // Clear coinciding with an output transfer
    cyc(1'b1, 1'b1, 1'b0, 1'b0, tv[0]);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("clr_pre_rdy", 64'(o_MS_rdy), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("clr_xfer_rdy", 64'(o_MS_rdy), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("clr_with_xfer", 64'(o_beat_cnt), 64'd0);

    // Reset mid-stream discards in-flight beats
    cyc(1'b1, 1'b1, 1'b0, 1'b0, tv[1]);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, tv[2]);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, tv[4]);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("post_rst_rdy", 64'(o_MS_rdy), 64'd0);
    end

    // Sixteen transfers wrap the 4-bit counter
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, tv[i % 6]);
    for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("wrap_cnt16", 64'(o_beat_cnt), 64'd16);
    chk("wrap_cnt4",  64'(u4_cnt),     64'd0);

    // Random traffic against the reference model
    do_reset();
    n_in = 0;
    cycles = 0;
    while (n_in < 100 && cycles < 3000) begin
      rv.mode = 2'($urandom_range(0, 3));
      rv.ip   = $urandom();
      rv.wp   = $urandom();
      rv.ps   = {$urandom(), $urandom()};
      rv.sd   = 8'($urandom());
      rv.esum = ref_sum(rv.mode, rv.ip, rv.wp);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0, 1'b0, rv);
      cycles++;
    end
    chk("rand_accepted", 64'(n_in), 64'd100);
    while (sb.size() > 0 && cycles < 3000) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      cycles++;
    end
    chk("rand_drained", 64'(sb.size()), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("rand_cnt",  64'(o_beat_cnt), 64'd100);
    chk("rand_cnt4", 64'(u4_cnt),     64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_stage_pipe.md
# mult_stage_pipe

Parametrised multiply stage of the PE datapath, sitting between the fetch stage (FS) and the sum stage (SS).
- Takes PEROW input/weight pixel pairs per beat, multiplies them in a selectable arithmetic mode, and returns the products. Each row's partial sum and the per-beat control sideband travel with the products.
- Results pass through an NSTAGE-deep, rdy/ack-handshaked pipeline that supports bubble collapse, flush and a beat counter.
- Replaces the fixed one-register, single-mode multiply stage.

## Interface
Parameters:
- DWD, 8, pixel width (even, ≥4)
- PSUMDWD, 16, partial-sum passthrough width
- PEROW, 4, rows (lanes) per beat
- NSTAGE, 2, pipeline depth, legal 1..4
- SIDEW, 8, control sideband width (SS ctl + PP ctl)
- CNTW, 16, beat counter width

Ports:
- i_clk  in  1  clock; all state changes on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_FS_rdy  in  1  upstream beat valid
- o_FS_ack  out  1  beat accepted this cycle (transfer = rdy & ack)
- i_ipix  in  PEROW×DWD  signed input pixels
- i_wpix  in  PEROW×DWD  signed weight pixels
- i_psum  in  PEROW×PSUMDWD  partial sums, passed through unchanged
- i_mode  in  2  arithmetic mode, sampled per beat
- i_side  in  SIDEW  sideband, passed through unchanged
- o_MS_rdy  out  1  output beat valid
- i_MS_ack  in  1  downstream accepts output
- o_sum  out  PEROW×2·DWD  signed products
- o_psum  out  PEROW×PSUMDWD  aligned partial sums
- o_side  out  SIDEW  aligned sideband
- i_flush  in  1  drop all in-flight beats
- i_clr  in  1  clear beat counter
- o_beat_cnt  out  CNTW  completed output transfers

## Operation
Arithmetic, per row and per beat. Mode travels with its beat.
- Mode 0: sum = signed(ipix) × signed(wpix), full 2·DWD bits.
- Mode 1, packed dual: split each operand into signed DWD/2 halves; sum = hi×hi + lo×lo, sign-extended to 2·DWD.
- Mode 2, bypass: sum = sign-extended ipix; wpix ignored.
- Mode 3, reserved: sum = 0; psum and side still pass through.

Pipeline:
- NSTAGE register stages, each with a valid bit v[k]. Stage 0 captures the computed products, psum and side on an input transfer. Later stages only delay.
- Advance: adv[N-1] = v[N-1] & i_MS_ack; adv[k] = v[k] & (!v[k+1] | adv[k+1]).
- o_FS_ack = !v[0] | adv[0], combinational from i_MS_ack. Bubbles collapse, so a full pipe with continuous ack accepts one beat per cycle.
- o_MS_rdy = v[N-1]. Outputs are driven from the last stage. Output data is held stable while rdy is high and ack is low.

Flush and reset:
- i_flush clears every v[k] next cycle and forces o_FS_ack = 0 that cycle. Data registers keep their values.
- Flush beats out-of-order with transfers: a transfer completing in the flush cycle still counts. Flush does not clear the counter.

Counter:
- o_beat_cnt increments on o_MS_rdy & i_MS_ack and wraps at 2^CNTW.
- i_clr sets it to 0. If clear and transfer occur in the same cycle, the result is 0.

## Timing
- Reset values: all v = 0, all data registers 0. Hence o_MS_rdy = 0, o_sum/o_psum/o_side = 0, o_beat_cnt = 0.
- o_FS_ack is 1 during reset, but nothing is captured; reset has priority over everything.
- Reset mid-operation discards all in-flight beats.
- Latency: an input accepted in cycle t appears with o_MS_rdy = 1 in cycle t+NSTAGE when there are no stalls.
- Throughput is 1 beat/cycle. Capacity is NSTAGE beats. When full and downstream is not acking, o_FS_ack = 0.
- Empty pipe with ack held: o_MS_rdy stays 0 and the counter does not move.

## Structure
- PECfg package: DWD, PSUMDWD, PEROW.
- PECtlCfg package:
  - MSmode enum (MS_FULL, MS_DUAL, MS_BYP, MS_RSV)
  - packed struct MSbeat {sum, psum, side}, used for stage registers
- One sub-module, mult_lane: combinational per-row arithmetic for all modes, instantiated PEROW times in a generate loop.

## Test plan
- Mode 0, NSTAGE=2, ipix=-3, wpix=7, continuous ack -> o_sum = -21 (0xFFEB) at t+2; psum/side match the input beat.
- Mode 1, DWD=8, ipix=0x3F (hi 3, lo -1), wpix=0x2E (hi 2, lo -2) -> o_sum = 6+2 = 8. Mode 2, ipix=0x80 -> o_sum = 0xFF80.
- Fill 2 beats with i_MS_ack=0 -> o_FS_ack drops after two accepts, o_sum held. Raise ack -> beats emerge in order with no loss and no duplication.
- 100 random beats under random rdy/ack -> output sequence equals the reference model and o_beat_cnt = 100.
- i_flush with 2 beats in flight -> o_MS_rdy = 0 next cycle, counter unchanged. i_rst mid-stream -> all outputs 0 next cycle.
- CNTW=4: 16 transfers -> counter wraps to 0. i_clr coinciding with a transfer -> counter = 0.
